// File: rtl/id_ex_reg_if.sv
// ID->EX pipeline bundle: decoded instruction fields from ID and the
// registered copies presented to EX.
interface id_ex_reg_if #(
  parameter int WIDTH = 32
);
  logic             id_valid;
  logic [WIDTH-1:0] id_pc_plus4;
  logic [WIDTH-1:0] id_rs_data;
  logic [WIDTH-1:0] id_rt_data;
  logic [WIDTH-1:0] id_imm;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_mem_to_reg;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_branch;
  logic             id_alu_src;
  logic             id_reg_dst;
  logic [1:0]       id_alu_op;
  logic [5:0]       id_funct;

  logic             ex_valid;
  logic [WIDTH-1:0] ex_pc_plus4;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic [WIDTH-1:0] ex_rt_data;
  logic [2:0]       ex_alu_control;
  logic [4:0]       ex_write_reg;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic             ex_reg_write;
  logic             ex_mem_to_reg;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_branch;

  modport master (
    output id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_reg_write, id_mem_to_reg, id_mem_read,
           id_mem_write, id_branch, id_alu_src, id_reg_dst, id_alu_op, id_funct,
    input  ex_valid, ex_pc_plus4, ex_a, ex_b, ex_rt_data, ex_alu_control,
           ex_write_reg, ex_rs, ex_rt, ex_reg_write, ex_mem_to_reg,
           ex_mem_read, ex_mem_write, ex_branch
  );

  modport slave (
    input  id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_reg_write, id_mem_to_reg, id_mem_read,
           id_mem_write, id_branch, id_alu_src, id_reg_dst, id_alu_op, id_funct,
    output ex_valid, ex_pc_plus4, ex_a, ex_b, ex_rt_data, ex_alu_control,
           ex_write_reg, ex_rs, ex_rt, ex_reg_write, ex_mem_to_reg,
           ex_mem_read, ex_mem_write, ex_branch
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: selects ALU operands, destination register and
// ALU control at load time; supports stall (hold) and flush (bubble).
module id_ex_reg #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       flush,
  id_ex_reg_if.slave bus
);
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] rt_data;
    logic [2:0]       alu_control;
    logic [4:0]       write_reg;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
  } ex_t;

  ex_t ex_d;
  ex_t ex_q;
  ex_t bubble;

  function automatic logic [2:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
    logic [2:0] ctl;
    ctl = ALU_ADD;
    case (op)
      2'b01: ctl = ALU_SUB;
      2'b10: begin
        case (funct)
          6'b100000: ctl = ALU_ADD;
          6'b100010: ctl = ALU_SUB;
          6'b100100: ctl = ALU_AND;
          6'b100101: ctl = ALU_OR;
          6'b101010: ctl = ALU_SLT;
          default:   ctl = ALU_ADD;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  always_comb begin
    bubble             = '0;
    bubble.alu_control = ALU_ADD;
  end

  // Controls are gated by id_valid so a non-instruction can never write back.
  always_comb begin
    ex_d             = '0;
    ex_d.valid       = bus.id_valid;
    ex_d.pc_plus4    = bus.id_pc_plus4;
    ex_d.a           = bus.id_rs_data;
    ex_d.b           = bus.id_alu_src ? bus.id_imm : bus.id_rt_data;
    ex_d.rt_data     = bus.id_rt_data;
    ex_d.alu_control = alu_decode(bus.id_alu_op, bus.id_funct);
    ex_d.write_reg   = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
    ex_d.rs          = bus.id_rs;
    ex_d.rt          = bus.id_rt;
    ex_d.reg_write   = bus.id_reg_write  & bus.id_valid;
    ex_d.mem_to_reg  = bus.id_mem_to_reg & bus.id_valid;
    ex_d.mem_read    = bus.id_mem_read   & bus.id_valid;
    ex_d.mem_write   = bus.id_mem_write  & bus.id_valid;
    ex_d.branch      = bus.id_branch     & bus.id_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= bubble;
    end else if (flush) begin
      ex_q <= bubble;
    end else if (!stall) begin
      ex_q <= ex_d;
    end
  end

  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_pc_plus4    = ex_q.pc_plus4;
  assign bus.ex_a           = ex_q.a;
  assign bus.ex_b           = ex_q.b;
  assign bus.ex_rt_data     = ex_q.rt_data;
  assign bus.ex_alu_control = ex_q.alu_control;
  assign bus.ex_write_reg   = ex_q.write_reg;
  assign bus.ex_rs          = ex_q.rs;
  assign bus.ex_rt          = ex_q.rt;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.ex_branch      = ex_q.branch;
endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: directed vectors push hand-computed EX
// state per edge; a negedge monitor pops and compares.
module tb_id_ex_reg;
  logic clk;
  logic rst_n;
  logic stall;
  logic flush;

  id_ex_reg_if #(.WIDTH(32)) bus ();

  id_ex_reg #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rtd;
    logic [2:0]  alu;
    logic [4:0]  wr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t bubble_exp();
    exp_t e;
    e     = '0;
    e.alu = 3'b010;
    return e;
  endfunction

  function automatic exp_t sample_dut();
    exp_t s;
    s.valid      = bus.ex_valid;
    s.pc         = bus.ex_pc_plus4;
    s.a          = bus.ex_a;
    s.b          = bus.ex_b;
    s.rtd        = bus.ex_rt_data;
    s.alu        = bus.ex_alu_control;
    s.wr         = bus.ex_write_reg;
    s.rs         = bus.ex_rs;
    s.rt         = bus.ex_rt;
    s.reg_write  = bus.ex_reg_write;
    s.mem_to_reg = bus.ex_mem_to_reg;
    s.mem_read   = bus.ex_mem_read;
    s.mem_write  = bus.ex_mem_write;
    s.branch     = bus.ex_branch;
    return s;
  endfunction

  // Monitor: one compare per clock edge that has an expectation queued.
  initial begin
    exp_t  e;
    exp_t  act;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = sample_dut();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got v=%0d pc=%h a=%h b=%h rtd=%h alu=%b wr=%0d rs=%0d rt=%0d ctl=%b%b%b%b%b required v=%0d pc=%h a=%h b=%h rtd=%h alu=%b wr=%0d rs=%0d rt=%0d ctl=%b%b%b%b%b",
                   nm, act.valid, act.pc, act.a, act.b, act.rtd, act.alu, act.wr, act.rs, act.rt,
                   act.reg_write, act.mem_to_reg, act.mem_read, act.mem_write, act.branch,
                   e.valid, e.pc, e.a, e.b, e.rtd, e.alu, e.wr, e.rs, e.rt,
                   e.reg_write, e.mem_to_reg, e.mem_read, e.mem_write, e.branch);
        end else begin
          $display("ok   %s: v=%0d a=%h b=%h alu=%b wr=%0d", nm, act.valid, act.a, act.b, act.alu, act.wr);
        end
      end
    end
  end

  task automatic clr_inputs();
    bus.id_valid      = 1'b0;
    bus.id_pc_plus4   = '0;
    bus.id_rs_data    = '0;
    bus.id_rt_data    = '0;
    bus.id_imm        = '0;
    bus.id_rs         = '0;
    bus.id_rt         = '0;
    bus.id_rd         = '0;
    bus.id_reg_write  = 1'b0;
    bus.id_mem_to_reg = 1'b0;
    bus.id_mem_read   = 1'b0;
    bus.id_mem_write  = 1'b0;
    bus.id_branch     = 1'b0;
    bus.id_alu_src    = 1'b0;
    bus.id_reg_dst    = 1'b0;
    bus.id_alu_op     = 2'b00;
    bus.id_funct      = 6'b000000;
  endtask

  task automatic tick(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic rtype(input logic [5:0] funct, input logic [31:0] pc,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    clr_inputs();
    bus.id_valid     = 1'b1;
    bus.id_alu_op    = 2'b10;
    bus.id_funct     = funct;
    bus.id_pc_plus4  = pc;
    bus.id_rs_data   = rsd;
    bus.id_rt_data   = rtd;
    bus.id_imm       = 32'h0000_0055;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_reg_dst   = 1'b1;
    bus.id_reg_write = 1'b1;
  endtask

  initial begin
    exp_t e;
    exp_t held;
    clr_inputs();
    rst_n = 1'b0;
    stall = 1'b1;
    flush = 1'b0;

    // Reset with stall high and a live-looking instruction on the inputs
    rtype(6'b101010, 32'h100, 32'd10, 32'd20, 5'd3, 5'd7, 5'd5);
    tick("reset", bubble_exp());

    rst_n = 1'b1;
    stall = 1'b0;
    rtype(6'b101010, 32'h104, 32'd10, 32'd20, 5'd3, 5'd7, 5'd5);
    e = bubble_exp();
    e.valid = 1; e.pc = 32'h104; e.a = 32'd10; e.b = 32'd20; e.rtd = 32'd20;
    e.alu = 3'b111; e.wr = 5'd5; e.rs = 5'd3; e.rt = 5'd7; e.reg_write = 1;
    tick("rtype_slt", e);

    clr_inputs();
    bus.id_valid = 1; bus.id_alu_op = 2'b00; bus.id_alu_src = 1; bus.id_imm = 32'hFFFF_FFFC;
    bus.id_rt = 5'd9; bus.id_rs = 5'd2; bus.id_rd = 5'd4; bus.id_reg_dst = 0;
    bus.id_mem_read = 1; bus.id_mem_to_reg = 1; bus.id_reg_write = 1;
    bus.id_rs_data = 32'h1000; bus.id_rt_data = 32'h33; bus.id_pc_plus4 = 32'h108;
    e = bubble_exp();
    e.valid = 1; e.pc = 32'h108; e.a = 32'h1000; e.b = 32'hFFFF_FFFC; e.rtd = 32'h33;
    e.alu = 3'b010; e.wr = 5'd9; e.rs = 5'd2; e.rt = 5'd9;
    e.reg_write = 1; e.mem_to_reg = 1; e.mem_read = 1;
    tick("itype_lw", e);

    bus.id_alu_op = 2'b01; bus.id_alu_src = 0; bus.id_branch = 1;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_to_reg = 0; bus.id_pc_plus4 = 32'h10C;
    e = bubble_exp();
    e.valid = 1; e.pc = 32'h10C; e.a = 32'h1000; e.b = 32'h33; e.rtd = 32'h33;
    e.alu = 3'b110; e.wr = 5'd9; e.rs = 5'd2; e.rt = 5'd9; e.branch = 1;
    tick("beq_sub", e);

    rtype(6'b100100, 32'h110, 32'hF0, 32'h3C, 5'd1, 5'd2, 5'd12);
    held = bubble_exp();
    held.valid = 1; held.pc = 32'h110; held.a = 32'hF0; held.b = 32'h3C; held.rtd = 32'h3C;
    held.alu = 3'b000; held.wr = 5'd12; held.rs = 5'd1; held.rt = 5'd2; held.reg_write = 1;
    tick("and_load", held);

    stall = 1'b1;
    rtype(6'b100101, 32'h114, 32'hAA, 32'h55, 5'd6, 5'd8, 5'd13);
    tick("stall1", held);
    bus.id_mem_write = 1; bus.id_alu_src = 1;
    tick("stall2", held);
    bus.id_mem_write = 0; bus.id_alu_src = 0;
    tick("stall3", held);

    stall = 1'b0;
    e = bubble_exp();
    e.valid = 1; e.pc = 32'h114; e.a = 32'hAA; e.b = 32'h55; e.rtd = 32'h55;
    e.alu = 3'b001; e.wr = 5'd13; e.rs = 5'd6; e.rt = 5'd8; e.reg_write = 1;
    tick("or_release", e);

    stall = 1'b1; flush = 1'b1;
    clr_inputs();
    bus.id_valid = 1; bus.id_mem_write = 1; bus.id_rs_data = 32'h44; bus.id_rt_data = 32'h66;
    bus.id_rt = 5'd11; bus.id_pc_plus4 = 32'h118;
    tick("flush_stall", bubble_exp());

    stall = 1'b0; flush = 1'b0;
    clr_inputs();
    bus.id_valid = 0; bus.id_reg_write = 1; bus.id_branch = 1;
    bus.id_rs_data = 32'd5; bus.id_rt_data = 32'd6; bus.id_rs = 5'd4; bus.id_rt = 5'd3;
    bus.id_pc_plus4 = 32'h11C;
    e = bubble_exp();
    e.pc = 32'h11C; e.a = 32'd5; e.b = 32'd6; e.rtd = 32'd6; e.wr = 5'd3; e.rs = 5'd4; e.rt = 5'd3;
    tick("invalid_gated", e);

    rtype(6'b000000, 32'h120, 32'd7, 32'd8, 5'd14, 5'd15, 5'd1);
    e = bubble_exp();
    e.valid = 1; e.pc = 32'h120; e.a = 32'd7; e.b = 32'd8; e.rtd = 32'd8;
    e.alu = 3'b010; e.wr = 5'd1; e.rs = 5'd14; e.rt = 5'd15; e.reg_write = 1;
    tick("funct_unknown", e);

    rtype(6'b100010, 32'h124, 32'd9, 32'd4, 5'd16, 5'd17, 5'd18);
    held = bubble_exp();
    held.valid = 1; held.pc = 32'h124; held.a = 32'd9; held.b = 32'd4; held.rtd = 32'd4;
    held.alu = 3'b110; held.wr = 5'd18; held.rs = 5'd16; held.rt = 5'd17; held.reg_write = 1;
    tick("sub_load", held);

    clr_inputs();
    bus.id_valid = 1; bus.id_alu_op = 2'b11; bus.id_funct = 6'b100010; bus.id_alu_src = 1;
    bus.id_imm = 32'h10; bus.id_rs_data = 32'h20; bus.id_rt = 5'd21; bus.id_mem_write = 1;
    bus.id_pc_plus4 = 32'h128;
    e = bubble_exp();
    e.valid = 1; e.pc = 32'h128; e.a = 32'h20; e.b = 32'h10; e.alu = 3'b010;
    e.wr = 5'd21; e.rt = 5'd21; e.mem_write = 1;
    tick("op11_sw", e);

    stall = 1'b1;
    rtype(6'b101010, 32'h12C, 32'd1, 32'd2, 5'd1, 5'd2, 5'd3);
    tick("stall_before_rst", e);

    rst_n = 1'b0;
    tick("reset_mid_stall", bubble_exp());

    rst_n = 1'b1; stall = 1'b0;
    rtype(6'b100000, 32'h130, 32'h7, 32'h9, 5'd22, 5'd23, 5'd24);
    bus.id_mem_write = 1;
    e = bubble_exp();
    e.valid = 1; e.pc = 32'h130; e.a = 32'h7; e.b = 32'h9; e.rtd = 32'h9;
    e.alu = 3'b010; e.wr = 5'd24; e.rs = 5'd22; e.rt = 5'd23; e.reg_write = 1; e.mem_write = 1;
    tick("add_after_rst", e);

    flush = 1'b1;
    tick("flush_only", bubble_exp());
    flush = 1'b0;
    clr_inputs();

    repeat (4) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
